ps2_mouse_tx: RTL
=================

// Module: ps2_mouse_tx
// PURPOSE
//  Device-side PS/2 transmitter: sends one byte from the mouse emulation to the host.
//  It generates PS2CLK and drives a standard 11-bit frame: start 0, 8 data bits LSB
//  first, odd parity, stop 1. It honours host inhibit (host pulls PS2CLK low).
//  Pairs with the device-side command receiver FSM; the packet sequencer sends ACK
//  (FA) and movement bytes through this block.
// PARAMETERS
//  HALF_CYC  1250  CLK cycles per PS2CLK half period (25us at 50MHz); >=8
//  IDLE_CYC  2500  CLK cycles PS2CLK must stay high before a frame starts (50us)
//  SYNC_IGN  4     cycles of each high phase ignored for inhibit checks (sync latency)
// PORTS
//  CLK         in   1  system clock
//  RST         in   1  asynchronous reset, active low
//  PS2CLK      in   1  PS/2 clock line as read from the pad (async, 2-FF synced inside)
//  PS2DATA     in   1  PS/2 data line as read from the pad (synced; unused in TX except for monitoring)
//  PS2CLKOUT   out  1  open-drain clock control: 0 = pull low, 1 = release
//  PS2DATAOUT  out  1  open-drain data control: 0 = pull low, 1 = release
//  DATA        in   8  byte to send; sampled on the SEND cycle
//  SEND        in   1  1-cycle request; accepted only when BUSY=0
//  BUSY        out  1  1 from the cycle after accept until DONE/ABORT
//  DONE        out  1  1-cycle pulse: frame fully sent
//  ABORT       out  1  1-cycle pulse: host inhibited before the 10th falling edge
// BEHAVIOUR
//  Reset (async, RST=0): PS2CLKOUT=1, PS2DATAOUT=1, BUSY=0, DONE=0, ABORT=0; state IDLE.
//   Takes effect immediately, including mid-frame; lines are released.
//  Data path:
//   - On accept, load shift reg {1, ^~DATA, DATA, 0} (11b). Parity = odd: the data
//     byte plus the parity bit contain an odd number of 1s.
//   - bitcnt 0..10; timer is wide enough for max(HALF_CYC, IDLE_CYC).
//  FSM:
//   IDLE     lines released; SEND=1 -> latch, WAIT_BUS, BUSY=1 next cycle.
//   WAIT_BUS lines released; count consecutive synced PS2CLK=1 cycles.
//            Any PS2CLK=0 clears the count. Count=IDLE_CYC -> BIT_HI, bitcnt=0.
//   BIT_HI   PS2DATAOUT=shift[0], PS2CLKOUT=1 for HALF_CYC cycles.
//            If bitcnt<=9, timer>=SYNC_IGN and synced PS2CLK=0: go to ABORTED.
//            Timer end -> BIT_LO.
//   BIT_LO   PS2CLKOUT=0 for HALF_CYC (falling edge = host sample point); data held.
//            End: bitcnt=10 -> FINISH; else shift right, bitcnt+1, go to BIT_HI.
//   FINISH   both lines released for HALF_CYC -> DONE=1 one cycle, IDLE, BUSY=0.
//   ABORTED  release both lines the same cycle; ABORT=1 one cycle; IDLE, BUSY=0.
//            No retry inside this block; the sequencer re-issues SEND.
//  Inhibit seen in the high phase before falling edge 11 (bitcnt=10) is ignored;
//   the frame completes.
//  Timing: 11 falling edges per frame, spaced 2*HALF_CYC.
//   First falling edge = IDLE_CYC+HALF_CYC (+/-2) cycles after accept on an idle bus.
//  SEND while BUSY=1 (including the DONE/ABORT cycle) is ignored; DATA is not sampled.
//  DONE and ABORT are mutually exclusive. BUSY=0 in the cycle after either pulse.
//  PS2CLKOUT/PS2DATAOUT are registered outputs (glitch-free).
// TESTING (bench: HALF_CYC=8, IDLE_CYC=16, SYNC_IGN=4, pull-ups modelled, bus = AND of drivers)
//  1 SEND DATA=FA on idle bus -> bits at the 11 falling edges: 0,0,1,0,1,1,1,1,1,1,1;
//    DONE 1 cycle; first edge ~24 cycles after SEND.
//  2 DATA=00 -> parity bit 1; DATA=01 -> parity 0; DATA=FF -> parity 1; stop always 1.
//  3 Host holds PS2CLK low at SEND, releases 40 cycles later -> no edges until 16 cycles
//    after release; then normal frame, DONE.
//  4 Host pulls PS2CLK low during the bit-3 high phase -> ABORT pulse, lines released
//    within 1 cycle, no further edges, BUSY=0.
//  5 Host pulls PS2CLK low after the 10th falling edge -> frame completes, DONE=1,
//    ABORT stays 0.
//  6 RST=0 mid-frame (bit 5 low phase) -> PS2CLKOUT=1, PS2DATAOUT=1, BUSY=0 without
//    waiting for CLK; SEND 2nd byte while BUSY -> ignored.

Source files
------------

// File: rtl/ps2_mouse_tx.sv
// Device-side PS/2 transmitter: generates PS2CLK and shifts out one 11-bit frame
// (start, 8 data LSB first, odd parity, stop), aborting if the host inhibits the clock.
module ps2_mouse_tx #(
   parameter int HALF_CYC = 1250,
   parameter int IDLE_CYC = 2500,
   parameter int SYNC_IGN = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PS2CLK,
   input  logic       PS2DATA,
   output logic       PS2CLKOUT,
   output logic       PS2DATAOUT,
   input  logic [7:0] DATA,
   input  logic       SEND,
   output logic       BUSY,
   output logic       DONE,
   output logic       ABORT
);

   localparam int MAX_CYC = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
   localparam int TW      = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BUS = 3'd1,
      BIT_HI   = 3'd2,
      BIT_LO   = 3'd3,
      FINISH   = 3'd4,
      ABORTED  = 3'd5
   } state_t;

   state_t         state_r, state_nxt;
   logic [TW-1:0]  timer_r, timer_nxt;
   logic [3:0]     bitcnt_r, bitcnt_nxt;
   logic [10:0]    shift_r, shift_nxt;
   logic [1:0]     clk_sync_r, data_sync_r;
   logic           clk_s;
   logic           clk_out_nxt, data_out_nxt, busy_nxt, done_nxt, abort_nxt;
   logic           unused_mon_s;

   assign clk_s = clk_sync_r[1];
   // The data line is synchronised for monitoring only; transmit never reads it.
   assign unused_mon_s = data_sync_r[1];

   // Two-flop synchronisers for the asynchronous pad inputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         clk_sync_r  <= 2'b11;
         data_sync_r <= 2'b11;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], PS2CLK};
         data_sync_r <= {data_sync_r[0], PS2DATA};
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_nxt  = state_r;
      timer_nxt  = timer_r;
      bitcnt_nxt = bitcnt_r;
      shift_nxt  = shift_r;
      done_nxt   = 1'b0;
      abort_nxt  = 1'b0;
      case (state_r)
         IDLE: begin
            timer_nxt = '0;
            if (SEND && !BUSY) begin
               shift_nxt = {1'b1, ~^DATA, DATA, 1'b0};
               state_nxt = WAIT_BUS;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT_BUS: begin
            if (!clk_s) begin
               timer_nxt = '0;
            end else if (timer_r == TW'(IDLE_CYC - 1)) begin
               timer_nxt  = '0;
               bitcnt_nxt = 4'd0;
               state_nxt  = BIT_HI;
            end else begin
               timer_nxt = timer_r + TW'(1);
            end
         end
         BIT_HI: begin
            // The first SYNC_IGN cycles still see our own low phase through the synchroniser.
            if ((bitcnt_r <= 4'd9) && (timer_r >= TW'(SYNC_IGN)) && !clk_s) begin
               timer_nxt = '0;
               abort_nxt = 1'b1;
               state_nxt = ABORTED;
            end else if (timer_r == TW'(HALF_CYC - 1)) begin
               timer_nxt = '0;
               state_nxt = BIT_LO;
            end else begin
               timer_nxt = timer_r + TW'(1);
            end
         end
         BIT_LO: begin
            if (timer_r == TW'(HALF_CYC - 1)) begin
               timer_nxt = '0;
               if (bitcnt_r == 4'd10) begin
                  state_nxt = FINISH;
               end else begin
                  shift_nxt  = {1'b1, shift_r[10:1]};
                  bitcnt_nxt = bitcnt_r + 4'd1;
                  state_nxt  = BIT_HI;
               end
            end else begin
               timer_nxt = timer_r + TW'(1);
            end
         end
         FINISH: begin
            if (timer_r == TW'(HALF_CYC - 1)) begin
               timer_nxt = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer_r + TW'(1);
            end
         end
         ABORTED: begin
            timer_nxt = '0;
            state_nxt = IDLE;
         end
         default: begin
            timer_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
      clk_out_nxt  = (state_nxt != BIT_LO);
      data_out_nxt = ((state_nxt == BIT_HI) || (state_nxt == BIT_LO)) ? shift_nxt[0] : 1'b1;
      // BUSY covers the DONE cycle so a SEND there is ignored.
      busy_nxt     = (state_nxt != IDLE) || done_nxt;
   end

   // State, datapath and glitch-free output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r    <= IDLE;
         timer_r    <= '0;
         bitcnt_r   <= 4'd0;
         shift_r    <= 11'h7FF;
         PS2CLKOUT  <= 1'b1;
         PS2DATAOUT <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ABORT      <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         timer_r    <= timer_nxt;
         bitcnt_r   <= bitcnt_nxt;
         shift_r    <= shift_nxt;
         PS2CLKOUT  <= clk_out_nxt;
         PS2DATAOUT <= data_out_nxt;
         BUSY       <= busy_nxt;
         DONE       <= done_nxt;
         ABORT      <= abort_nxt;
      end
   end

endmodule
